// File: rtl/skid_buf7.sv
// ---------------------------------------------------------------------------
// skid_buf7 -- two-entry elastic pipeline register for a 7-bit payload.
//
// Sits between two pipeline stages with a valid/ready handshake on each side.
// The head entry (main) drives out_data. The skid entry absorbs the one word
// that was accepted in the cycle in which the consumer stalled. in_ready is
// decoded from the state register only, so out_ready never reaches in_ready
// combinationally.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset (overrides flush_i)
//   flush_i      synchronous flush, discards all held entries
//   in_valid_i   upstream offers in_data_i
//   in_ready_o   buffer can accept a word this cycle
//   in_data_i    upstream payload (7 bits)
//   out_valid_o  out_data_o holds a valid word
//   out_ready_i  downstream accepts out_data_o this cycle
//   out_data_o   head-of-buffer payload (7 bits)
//   count_o      number of held entries: 0, 1 or 2
// ---------------------------------------------------------------------------
module skid_buf7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [6:0] in_data_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [6:0] out_data_o,
  output logic [1:0] count_o
);

  // State encoding equals the number of held entries, so count is the state.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [6:0] main_q,  main_d;
  logic [6:0] skid_q,  skid_d;
  logic       in_xfer_s;

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready_o  = (state_q != FULL) & ~rst_i;
    out_valid_o = (state_q != EMPTY);
    out_data_o  = main_q;
    count_o     = state_q;
    in_xfer_s   = in_valid_i & in_ready_o;
  end

  // Next-state and storage-enable logic; flush overrides every transfer rule.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Contents are left as-is; out_valid=0 in EMPTY hides them.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_s) begin
            main_d  = in_data_i;
            state_d = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer_s && out_ready_i) begin
            // Pass-through: head leaves while the new word replaces it.
            main_d  = in_data_i;
            state_d = ONE;
          end else if (in_xfer_s) begin
            skid_d  = in_data_i;
            state_d = FULL;
          end else if (out_ready_i) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        FULL: begin
          // in_ready is low here, so no input can be taken.
          if (out_ready_i) begin
            main_d  = skid_q;
            state_d = ONE;
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe, empty state.
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= 7'h00;
      skid_q  <= 7'h00;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_buf7.sv
module tb_skid_buf7;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0] in_data, out_data;
  logic [1:0] count;

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  skid_buf7 dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .count_o(count)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer pops the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_output: got %h, expected nothing at %0t", out_data, $time);
      end else begin
        chk("out_data", {1'b0, out_data}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- Reset ----
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 7'h55; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      @(negedge clk);
      chk("rst_out_valid", {7'b0, out_valid}, 8'd0);
      chk("rst_in_ready",  {7'b0, in_ready},  8'd0);
      chk("rst_count",     {6'b0, count},     8'd0);
      chk("rst_out_data",  {1'b0, out_data},  8'h00);
    end
    tick;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {7'b0, in_ready}, 8'd1);
    tick;
    @(negedge clk);
    chk("post_rst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("post_rst_count",     {6'b0, count},     8'd0);

    // ---- Streaming 01..10 with out_ready high ----
    tick;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; in_data = 7'(i);
      exp_q.push_back(7'(i));
      @(negedge clk);
      chk("stream_in_ready", {7'b0, in_ready}, 8'd1);
      if (i > 1) begin
        chk("stream_count", {6'b0, count}, 8'd1);
        chk("stream_head",  {1'b0, out_data}, 8'(i - 1));
      end
      tick;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", {7'b0, out_valid}, 8'd1);
    tick;
    @(negedge clk);
    chk("stream_end_count", {6'b0, count}, 8'd0);

    // ---- Stall and skid ----
    tick;
    out_ready = 1'b0;
    exp_q.push_back(7'h11); exp_q.push_back(7'h22); exp_q.push_back(7'h33);
    in_valid = 1'b1; in_data = 7'h11;
    tick;
    in_data = 7'h22;
    @(negedge clk);
    chk("stall_in_ready_one", {7'b0, in_ready}, 8'd1);
    chk("stall_count_one",    {6'b0, count},    8'd1);
    tick;
    in_data = 7'h33;
    @(negedge clk);
    chk("stall_in_ready_full", {7'b0, in_ready}, 8'd0);
    chk("stall_count_full",    {6'b0, count},    8'd2);
    chk("stall_head",          {1'b0, out_data}, 8'h11);
    tick;
    @(negedge clk);
    chk("full_hold_count", {6'b0, count},    8'd2);
    chk("full_hold_head",  {1'b0, out_data}, 8'h11);
    tick;
    out_ready = 1'b1;
    tick;
    @(negedge clk);
    chk("recover_in_ready", {7'b0, in_ready},  8'd1);
    chk("recover_valid",    {7'b0, out_valid}, 8'd1);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("skid_third_valid", {7'b0, out_valid}, 8'd1);
    tick;
    @(negedge clk);
    chk("skid_drained_count", {6'b0, count}, 8'd0);

    // ---- Empty drain ----
    tick;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h7F;
    exp_q.push_back(7'h7F);
    tick;
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    @(negedge clk);
    chk("drain_valid_0", {7'b0, out_valid}, 8'd0);
    tick;
    tick;
    @(negedge clk);
    chk("drain_valid_1", {7'b0, out_valid}, 8'd0);
    chk("drain_count",   {6'b0, count},     8'd0);

    // ---- Flush in FULL ----
    tick;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h0A;
    tick;
    in_data = 7'h0B;
    tick;
    in_data = 7'h0C; flush = 1'b1;
    @(negedge clk);
    chk("preflush_count", {6'b0, count}, 8'd2);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {7'b0, out_valid}, 8'd0);
    chk("flush_count",     {6'b0, count},     8'd0);
    chk("flush_in_ready",  {7'b0, in_ready},  8'd1);
    out_ready = 1'b1;
    tick; tick; tick;
    out_ready = 1'b0;

    // ---- Reset mid-stream with flush ----
    in_valid = 1'b1; in_data = 7'h21;
    tick;
    in_data = 7'h42;
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_count", {6'b0, count}, 8'd2);
    rst = 1'b1; flush = 1'b1;
    tick;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("mid_rst_count",     {6'b0, count},     8'd0);
    chk("mid_rst_out_data",  {1'b0, out_data},  8'h00);
    chk("mid_rst_in_ready",  {7'b0, in_ready},  8'd1);
    tick;
    in_valid = 1'b1; in_data = 7'h5A; out_ready = 1'b1;
    exp_q.push_back(7'h5A);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_latency_valid", {7'b0, out_valid}, 8'd1);
    tick; tick;

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
